// File: rtl/mutant_family_pkg.sv
// Shared types and constants for the mutant family generator.
package mutant_family_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUTATE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    MODE_SWAP = 1'b0,
    MODE_REV  = 1'b1
  } mode_e;

  // Galois feedback taps for the 32-bit LFSR.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // An all-zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [31:0] SEED_SUBST = 32'h0000_0001;

  // One Galois step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/mutant_family_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enables.
module lfsr32
  import mutant_family_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  // Load takes priority over step; a zero seed is substituted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED_SUBST;
    end else if (load) begin
      state <= (seed == '0) ? SEED_SUBST : seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/mutant_family.sv
// Builds a family: the parent plus N_MUTANTS mutated copies, one
// swap or segment-reversal operation per clock.
module mutant_family
  import mutant_family_pkg::*;
#(
  parameter int GENE_W    = 10,
  parameter int N_GENES   = 15,
  parameter int N_MUTANTS = 4,
  parameter int SWAPS     = 1,
  localparam int CHROM_W  = GENE_W * N_GENES,
  localparam int FAM_W    = CHROM_W * (N_MUTANTS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [31:0]        prg_seed,
  input  logic [CHROM_W-1:0] parent,
  output logic [FAM_W-1:0]   family,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  mode_e              mode_q;
  logic [4:0]         mut_cnt, swap_cnt;
  logic               last_swap, last_mut;
  logic [31:0]        lfsr_q;
  logic               lfsr_load, lfsr_step;
  logic [FAM_W-1:0]   fam_q;
  logic               busy_d, done_d, busy_q, done_q;
  logic [7:0]         idx_i, idx_j, lo, hi;
  logic [CHROM_W-1:0] cur_chrom, mut_chrom;

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (prg_seed),
    .step  (lfsr_step),
    .state (lfsr_q)
  );

  assign last_swap = (swap_cnt == 5'(SWAPS - 1));
  assign last_mut  = (mut_cnt == 5'(N_MUTANTS - 1));

  // Scale each 16-bit LFSR half into 0..N_GENES-1 by multiply-and-shift.
  assign idx_i = 8'(({8'b0, lfsr_q[15:0]}  * 24'(N_GENES)) >> 16);
  assign idx_j = 8'(({8'b0, lfsr_q[31:16]} * 24'(N_GENES)) >> 16);
  assign lo    = (idx_i < idx_j) ? idx_i : idx_j;
  assign hi    = (idx_i < idx_j) ? idx_j : idx_i;

  // Select the mutant currently being worked on (slot mut_cnt+1).
  always_comb begin
    cur_chrom = fam_q[CHROM_W +: CHROM_W];
    for (int unsigned k = 1; k <= N_MUTANTS; k++) begin
      if (32'(mut_cnt) + 32'd1 == k) begin
        cur_chrom = fam_q[k*CHROM_W +: CHROM_W];
      end
    end
  end

  // Apply one swap or reversal; i==j naturally leaves the mutant unchanged.
  always_comb begin
    mut_chrom = cur_chrom;
    if (mode_q == MODE_SWAP) begin
      mut_chrom[32'(idx_i)*GENE_W +: GENE_W] = cur_chrom[32'(idx_j)*GENE_W +: GENE_W];
      mut_chrom[32'(idx_j)*GENE_W +: GENE_W] = cur_chrom[32'(idx_i)*GENE_W +: GENE_W];
    end else begin
      for (int unsigned k = 0; k < N_GENES; k++) begin
        if (k >= 32'(lo) && k <= 32'(hi)) begin
          mut_chrom[k*GENE_W +: GENE_W] =
            cur_chrom[(32'(lo) + 32'(hi) - k)*GENE_W +: GENE_W];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, LFSR control and next values of the busy/done flags.
  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          state_d   = S_MUTATE;
        end
      end
      S_MUTATE: begin
        lfsr_step = 1'b1;
        busy_d    = 1'b1;
        if (last_swap && last_mut) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Family storage, latched mode and operation counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fam_q    <= '0;
      mode_q   <= MODE_SWAP;
      mut_cnt  <= '0;
      swap_cnt <= '0;
    end else if (state_q == S_IDLE && start) begin
      fam_q    <= {(N_MUTANTS + 1){parent}};
      mode_q   <= mode_e'(mode);
      mut_cnt  <= '0;
      swap_cnt <= '0;
    end else if (state_q == S_MUTATE) begin
      for (int unsigned k = 1; k <= N_MUTANTS; k++) begin
        if (32'(mut_cnt) + 32'd1 == k) begin
          fam_q[k*CHROM_W +: CHROM_W] <= mut_chrom;
        end
      end
      if (last_swap) begin
        swap_cnt <= '0;
        mut_cnt  <= mut_cnt + 5'd1;
      end else begin
        swap_cnt <= swap_cnt + 5'd1;
      end
    end
  end

  assign family = fam_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/mutant_family.md
MUTANT_FAMILY -- requirements
Module: mutant_family

Interface
REQ-001 Parameter GENE_W, default 10: bits per gene (one city index).
REQ-002 Parameter N_GENES, default 15: genes per chromosome, legal range 2..255.
REQ-003 Parameter N_MUTANTS, default 4: mutants generated per family, legal range 1..16.
REQ-004 Parameter SWAPS, default 1: mutation operations applied to each mutant, legal range 1..16.
REQ-005 Derived constants: CHROM_W = GENE_W*N_GENES and FAM_W = CHROM_W*(N_MUTANTS+1).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request to build a family; sampled only in IDLE.
REQ-009 mode  input  1  mutation operator: 0 = gene swap, 1 = segment reversal; latched at start.
REQ-010 prg_seed  input  32  LFSR seed; latched at start.
REQ-011 parent  input  CHROM_W  source chromosome; latched at start.
REQ-012 family  output  FAM_W  slot k occupies bits [k*CHROM_W +: CHROM_W]; slot 0 = latched parent, slots 1..N_MUTANTS = mutants.
REQ-013 busy  output  1  high from the cycle after start acceptance until the done pulse.
REQ-014 done  output  1  single-cycle completion pulse.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, MUTATE, DONE.
REQ-016 IDLE with start=1 at edge T: latch parent into slot 0 and every mutant slot, latch mode, load the LFSR (seed 0 replaced by 32'h0000_0001), clear the counters, and enter MUTATE.
REQ-017 MUTATE: exactly one operation per cycle on mutant m = mut_cnt+1, using swap index s = swap_cnt.
REQ-018 Operation m, s SHALL complete at edge T+1+(m-1)*SWAPS+s.
REQ-019 Each operation's indices: i = (L[15:0]*N_GENES)>>16 and j = (L[31:16]*N_GENES)>>16, where L is the current LFSR state; both indices always fall in 0..N_GENES-1.
REQ-020 Mode 0: exchange genes i and j of the mutant.
REQ-021 Mode 1: reverse the gene order between min(i,j) and max(i,j) inclusive.
REQ-022 i==j SHALL leave the mutant unchanged in both modes.
REQ-023 The LFSR SHALL advance once per operation: Galois form, next = (L>>1) ^ (L[0] ? 32'h8020_0003 : 0).
REQ-024 Every mutant starts as a copy of the parent; mutations never carry over between mutants.
REQ-025 swap_cnt SHALL wrap from SWAPS-1 to 0 and increment mut_cnt; after the last operation of mutant N_MUTANTS, enter DONE.
REQ-026 DONE: done=1 for one cycle at edge T+1+N_MUTANTS*SWAPS, then return to IDLE.
REQ-027 The family output SHALL hold stable from the done pulse until the next accepted start.
REQ-028 start in MUTATE or DONE SHALL be ignored and is not queued.
REQ-029 Inputs parent, mode and prg_seed SHALL have no effect except when start is accepted.
REQ-030 Every mutant SHALL be a permutation of the parent, preserving the multiset of genes.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, busy=0, done=0, family=0, LFSR=32'h1, and counters=0, including mid-MUTATE.
REQ-032 After rst_n is released, the first start SHALL be accepted no earlier than the first rising edge at which rst_n is high.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the LFSR tap constant 32'h8020_0003, the seed-substitute constant, and the mode encodings.
REQ-034 The LFSR SHALL be a separate sub-module lfsr32 (ports clk, rst_n, load, seed, step, state).
REQ-035 The index scaling and the swap/reverse datapath stay in mutant_family.

Verification
REQ-036 Seed 0, mode 0, N_MUTANTS=4, SWAPS=1, start at T: L=1 gives i=j=0, so mutant 1 equals the parent; done exactly at T+5; busy high T+1..T+4.
REQ-037 Random parent as a permutation of 0..14 with seeds 1..1000 in both modes: every slot 1..4 is a permutation of 0..14 and slot 0 equals the parent.
REQ-038 Golden-model compare (the REQ-019/023 formulas) for SWAPS=3, mode 1, seed 32'hDEAD_BEEF: bit-exact family; done at T+13.
REQ-039 start held high throughout MUTATE, parent changed mid-run: the result is unchanged and exactly one done pulse occurs; a new family starts only after the return to IDLE.
REQ-040 rst_n asserted at T+2 of a run: family=0, busy=0, done=0 asynchronously; no done pulse; a following start completes normally.
REQ-041 Parameter sweep GENE_W=8, N_GENES=2, N_MUTANTS=1: done at T+1+SWAPS and indices stay within 0..1.
